// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive block: deframer state encoding,
// register offsets inside the UART window and STATUS register bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    localparam int unsigned ST_VALID = 0;
    localparam int unsigned ST_FERR  = 1;
    localparam int unsigned ST_OVR   = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data
//   pop             read request (ignored when empty)
//   full, empty     occupancy flags
//   head            entry at the read pointer (undefined when empty)
// A push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // The slot freed by a simultaneous pop makes room for the push.
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART receiver with memory-mapped DATA/STATUS registers.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   rx_pin        asynchronous serial input, idle high (8N1)
//   bus_addr      byte offset in the UART window, bits [3:2] decoded
//   bus_ren       read strobe; a DATA read pops one FIFO entry
//   bus_wen       write strobe; STATUS writes clear sticky flags
//   bus_wdata     write data
//   mmio_rdata    combinational read data
//   rx_valid      FIFO not empty
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    input  logic [3:0]  bus_addr,
    input  logic        bus_ren,
    input  logic        bus_wen,
    input  logic [31:0] bus_wdata,
    output logic [31:0] mmio_rdata,
    output logic        rx_valid
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta, rxs;
    rx_state_t       state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            frame_err, frame_err_d;
    logic            overrun, overrun_d;
    logic            push, ferr_set;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_head;
    logic [1:0]      sel;
    logic            pop, status_wr;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:3], bus_wdata[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shift     <= shift_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

    // Deframer: samples mid-bit by waiting half a bit in START, then whole bits.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx] = rxs;
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel       = bus_addr[3:2];
    assign pop       = bus_ren && (sel == REG_DATA[3:2]) && !fifo_empty;
    assign status_wr = bus_wen && (sel == REG_STATUS[3:2]);

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        frame_err_d = frame_err;
        overrun_d   = overrun;
        if (status_wr && bus_wdata[ST_FERR]) frame_err_d = 1'b0;
        if (status_wr && bus_wdata[ST_OVR])  overrun_d   = 1'b0;
        if (ferr_set)                        frame_err_d = 1'b1;
        if (push && fifo_full && !pop)       overrun_d   = 1'b1;
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign rx_valid = !fifo_empty;

    always_comb begin
        status           = '0;
        status[ST_VALID] = rx_valid;
        status[ST_FERR]  = frame_err;
        status[ST_OVR]   = overrun;
    end

    always_comb begin
        mmio_rdata = '0;
        case (sel)
            REG_DATA[3:2]:   mmio_rdata = fifo_empty ? 32'h0 : {24'h0, fifo_head};
            REG_STATUS[3:2]: mmio_rdata = status;
            default:         mmio_rdata = '0;
        endcase
    end

endmodule
